// File: rtl/aes_block_feeder_if.sv
// rtl/aes_block_feeder_if.sv - data-buffer read port and AES block stream
// master = feeder side, slave = buffer/AES-core side.
interface aes_block_feeder_if #(
  parameter int BUS_WIDTH   = 32,
  parameter int BLOCK_WIDTH = 128,
  parameter int ADDR_WIDTH  = 10
);
  logic                   buf_rd_en;
  logic [ADDR_WIDTH-1:0]  buf_rd_addr;
  logic [BUS_WIDTH-1:0]   buf_rd_data;
  logic                   blk_valid;
  logic [BLOCK_WIDTH-1:0] blk_data;
  logic                   blk_last;
  logic                   blk_ready;

  modport master (
    output buf_rd_en, buf_rd_addr, blk_valid, blk_data, blk_last,
    input  buf_rd_data, blk_ready
  );

  modport slave (
    input  buf_rd_en, buf_rd_addr, blk_valid, blk_data, blk_last,
    output buf_rd_data, blk_ready
  );
endinterface

// File: rtl/aes_block_feeder.sv
// rtl/aes_block_feeder.sv - packs buffer words into PKCS#7-padded 128-bit AES blocks
// Fixed 4-cycle fetch + 1 drain cycle per block, one block in flight.
module aes_block_feeder #(
  parameter int BUS_WIDTH   = 32,
  parameter int BLOCK_WIDTH = 128,
  parameter int LEN_WIDTH   = 12,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [LEN_WIDTH-1:0] data_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  aes_block_feeder_if.master   bus
);
  localparam int BLK_W = LEN_WIDTH - 4;
  localparam int IDX_W = LEN_WIDTH - 2;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_PRESENT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [BLK_W-1:0]       blk_q, blk_d;
  logic [1:0]             wrd_q, wrd_d;
  logic [BLOCK_WIDTH-1:0] data_q, data_d;

  logic [IDX_W-1:0]       word_idx;
  logic [1:0]             cap_slot;
  logic [7:0]             pad_byte;
  logic [BUS_WIDTH-1:0]   cap_word;
  logic                   is_last;

  assign word_idx = {blk_q, wrd_q};
  // Read data lags the strobe by one cycle, so each cycle captures the previous slot.
  assign cap_slot = (state_q == S_DRAIN) ? 2'd3 : wrd_q - 2'd1;
  assign pad_byte = 8'd16 - {4'd0, len_q[3:0]};
  assign is_last  = (blk_q == len_q[LEN_WIDTH-1:4]);

  // Bytes at or past the message end become pad, whatever the buffer returned.
  for (genvar k = 0; k < 4; k++) begin : g_byte
    logic [LEN_WIDTH-1:0] byte_idx;
    assign byte_idx = {blk_q, cap_slot, 2'(k)};
    assign cap_word[BUS_WIDTH-1-8*k -: 8] =
      (byte_idx < len_q) ? bus.buf_rd_data[BUS_WIDTH-1-8*k -: 8] : pad_byte;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      blk_q   <= '0;
      wrd_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      blk_q   <= blk_d;
      wrd_q   <= wrd_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    blk_d   = blk_q;
    wrd_d   = wrd_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          len_d   = data_len_i;
          blk_d   = '0;
          wrd_d   = '0;
        end
      end
      S_FETCH: begin
        wrd_d = wrd_q + 2'd1;
        if (wrd_q != 2'd0) begin
          data_d[BLOCK_WIDTH-1-BUS_WIDTH*int'(cap_slot) -: BUS_WIDTH] = cap_word;
        end
        if (wrd_q == 2'd3) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        data_d[BLOCK_WIDTH-1-BUS_WIDTH*int'(cap_slot) -: BUS_WIDTH] = cap_word;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (bus.blk_ready) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            blk_d   = blk_q + 1'b1;
            wrd_d   = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
    end
  end

  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign bus.buf_rd_en   = (state_q == S_FETCH) && ({word_idx, 2'b00} < len_q);
  assign bus.buf_rd_addr = bus.buf_rd_en ? ADDR_WIDTH'(word_idx) : '0;
  assign bus.blk_valid   = (state_q == S_PRESENT);
  assign bus.blk_data    = bus.blk_valid ? data_q : '0;
  assign bus.blk_last    = bus.blk_valid && is_last;
endmodule
